// File: rtl/minmax_sample_loader.sv
// minmax_sample_loader
//
// Input stage for the min/max finder. Synchronizes the switch bus and two
// push buttons, debounces the buttons, and turns each debounced load press
// into one sample offered over a valid/ready handshake. A debounced clear
// press emits a one-cycle clear strobe and resets the sample bookkeeping.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   sw_data       raw switch value (asynchronous)
//   btn_load      raw load button, active-high (asynchronous)
//   btn_clear     raw clear button, active-high (asynchronous)
//   out_valid     a sample is pending for the min/max finder
//   out_data      pending sample, stable while out_valid is high
//   out_first     pending sample is the first since reset or clear
//   out_ready     min/max finder accepts the sample
//   clr_pulse     one-cycle clear strobe to the min/max finder
//   sample_count  samples transferred since clear (saturating)
//   full          sample_count == MAX_SAMPLES
//   overrun       sticky: a load press was dropped
module minmax_sample_loader #(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_SAMPLES     = 16,
  localparam int CNT_W          = $clog2(MAX_SAMPLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              btn_load,
  input  logic              btn_clear,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
  input  logic              out_ready,
  output logic              clr_pulse,
  output logic [CNT_W-1:0]  sample_count,
  output logic              full,
  output logic              overrun
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SAMPLES);

  // Button index inside the packed button vectors.
  localparam int BTN_LOAD  = 0;
  localparam int BTN_CLEAR = 1;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // Count one more transfer, holding at MAX_SAMPLES instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_MAX) sat_inc = CNT_MAX;
    else              sat_inc = c + 1'b1;
  endfunction

  logic [DATA_W-1:0] sw_p0, sw_p1;
  logic [1:0]        btn_p0, btn_p1;
  logic [1:0]        stable, stable_d;
  logic [DB_W-1:0]   db_cnt [2];

  logic   load_evt, clr_evt;
  state_t state, state_nxt;
  logic   capture, xfer;

  // ---- stage p0/p1: two-flop synchronizers, then debounce ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_p0    <= '0;
      sw_p1    <= '0;
      btn_p0   <= '0;
      btn_p1   <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sw_p0    <= sw_data;
      sw_p1    <= sw_p0;
      btn_p0   <= {btn_clear, btn_load};
      btn_p1   <= btn_p0;
      stable_d <= stable;
      for (int i = 0; i < 2; i++) begin
        // Any cycle of agreement restarts the stability window.
        if (btn_p1[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= btn_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press events: one cycle on a debounced 0->1 transition only.
  assign load_evt = stable[BTN_LOAD]  & ~stable_d[BTN_LOAD];
  assign clr_evt  = stable[BTN_CLEAR] & ~stable_d[BTN_CLEAR];

  assign full = (sample_count == CNT_MAX);

  // ---- stage p2: load FSM and sample bookkeeping ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    xfer      = 1'b0;
    out_valid = (state == PEND);
    if (clr_evt) begin
      // Clear overrides everything: a pending sample is discarded and a
      // simultaneous load or transfer is ignored.
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (load_evt && !full) begin
            capture   = 1'b1;
            state_nxt = PEND;
          end
        end
        PEND: begin
          if (out_ready) begin
            xfer      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data     <= '0;
      out_first    <= 1'b0;
      clr_pulse    <= 1'b0;
      sample_count <= '0;
      overrun      <= 1'b0;
    end else begin
      clr_pulse <= clr_evt;
      if (clr_evt) begin
        sample_count <= '0;
        overrun      <= 1'b0;
      end else begin
        if (xfer) sample_count <= sat_inc(sample_count);
        // A press is dropped while a sample waits or once the set is full.
        if (load_evt && ((state == PEND) || full)) overrun <= 1'b1;
      end
      if (capture) begin
        out_data  <= sw_p1;
        out_first <= (sample_count == '0);
      end
    end
  end

endmodule

// File: doc/minmax_sample_loader.md
# minmax_sample_loader

Upstream input stage for the min/max finder. It synchronizes and debounces two push buttons (load and clear) and captures the switch value on each debounced load press. Each captured sample is presented to the min/max finder over a valid/ready handshake, with a first-sample flag so the finder can seed its min and max registers. It also counts the samples accepted since the last clear.

## Interface
- DATA_W, 8, width of switch data and output sample
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a button level change is accepted (≥2)
- MAX_SAMPLES, 16, samples accepted before full; CNT_W = clog2(MAX_SAMPLES+1)
- clk  in  1  system clock; all logic is on the rising edge
- rst_n  in  1  asynchronous active-low reset
- sw_data  in  DATA_W  raw switch value (asynchronous)
- btn_load  in  1  raw load button, active-high (asynchronous)
- btn_clear  in  1  raw clear button, active-high (asynchronous)
- out_valid  out  1  sample is pending for the min/max finder
- out_data  out  DATA_W  pending sample; stable while out_valid is high
- out_first  out  1  pending sample is the first since reset or clear
- out_ready  in  1  min/max finder accepts the sample
- clr_pulse  out  1  one-cycle clear strobe to the min/max finder
- sample_count  out  CNT_W  samples transferred since clear
- full  out  1  sample_count == MAX_SAMPLES
- overrun  out  1  sticky flag: a load press was dropped

## Operation
- sw_data, btn_load and btn_clear each pass through a 2-FF synchronizer.
- Per-button debouncer:
  - stable level resets to 0.
  - A counter runs while the synchronized level differs from stable and resets to 0 on any cycle where they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, stable flips at the next edge and the counter clears.
- Event = stable rising edge (a 0→1 transition), one cycle wide. A release produces no event, and holding a button produces only one event.
- Load FSM has two states.
  - IDLE: on a load event with full=0, capture the synchronized sw_data into out_data, set out_first = (sample_count==0), then go to PEND. A load event with full=1 is dropped and sets overrun.
  - PEND: out_valid=1. On out_valid&out_ready, sample_count increments and the FSM returns to IDLE. A load event in PEND is dropped and sets overrun; out_data is unchanged.
- Clear event:
  - clr_pulse=1 for exactly one cycle.
  - The next edge sets sample_count=0, full=0 and overrun=0, and the FSM goes to IDLE. Any pending sample is discarded without a transfer.
- Simultaneous events:
  - Clear and load events in the same cycle: clear wins and the load is dropped without setting overrun.
  - Clear in the same cycle as a transfer: the transfer is not counted.
- full is combinational from sample_count. sample_count saturates at MAX_SAMPLES and never wraps.

## Timing
- Reset values of all outputs are 0: out_valid, out_data, out_first, clr_pulse, sample_count, full and overrun. The FSM resets to IDLE, and synchronizers, stable levels and counters reset to 0.
- Reset takes effect immediately on rst_n falling, mid-debounce or mid-handshake. A pending sample is lost, and the first edge after release starts from the reset state.
- Latency: a raw press is set before edge 1 and held. The synchronized level is 1 after edge 2, stable rises at edge DEBOUNCE_CYCLES+2, and out_valid rises after edge DEBOUNCE_CYCLES+3. clr_pulse rises with the same latency.
- out_data is the synchronized sw_data from the event cycle, so sw_data must be stable for 2 cycles before the event.
- Handshake:
  - out_valid stays high until sampled with out_ready=1; it drops after that edge.
  - The earliest next out_valid needs a new event.
  - out_ready while out_valid=0 is ignored.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no event.

## Test plan
Use DEBOUNCE_CYCLES=4 and MAX_SAMPLES=3 for all scenarios.
- Reset, then press load with sw_data=8'hA5 and out_ready=1 -> out_valid is high for one cycle after edge 7 with out_data=A5 and out_first=1; then sample_count=1.
- Pulse btn_load for 3 cycles only -> no out_valid and sample_count stays 0. Then bounce 1-0-1 and hold -> exactly one event.
- Set out_ready=0, press load (sw_data=8'h10), then press again (sw_data=8'h20) -> out_data stays 10 and overrun=1. Raise out_ready -> one transfer, and sample_count=1.
- Complete three transfers (values 3, 9, 1) -> out_first only on 3, full=1 after the third. A fourth press -> no out_valid, overrun=1, sample_count=3.
- Press clear while a sample is pending -> one clr_pulse, out_valid drops, sample_count=0, full=0, overrun=0. The next load gives out_first=1.
- Assert rst_n=0 mid-debounce and mid-PEND -> all outputs go to 0 at once, and no stale event appears after release.
